dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the 128-byte byte-addressed data memory. It shares the memory between the processor load/store path (port 0) and a debug/loader requester (port 1) using round-robin arbitration and a valid/ready request handshake. It checks alignment, range and funct3 legality, then drives the memory's read/write/funct3/addr/data lines for exactly one access cycle. It returns read data and an error flag as a registered one-cycle response pulse to the owning port.

---
 rtl/dmem_arbiter.sv | 277 +++++++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Purpose:
//   Shares a small byte-addressed data memory between two requesters using
//   round-robin arbitration. Each accepted request is checked for funct3
//   legality, alignment and range. It then gets exactly one memory access
//   cycle, followed by a registered one-cycle response pulse to the port that
//   issued it.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   pN_req_valid/ready     request handshake (N = 0 processor, 1 debug/loader)
//   pN_req_write           1 = store, 0 = load
//   pN_req_funct3          RV32 load/store funct3
//   pN_req_addr            byte address
//   pN_req_wdata           store data (low bytes used for SB/SH)
//   pN_rsp_valid           one-cycle response pulse
//   pN_rsp_rdata           load result, 0 for stores and rejected requests
//   pN_rsp_err             request rejected, no memory access performed
//   mem_read/mem_write     memory enables, only ever high in the access cycle
//   mem_funct3/addr/wdata  memory command
//   mem_rdata              combinational read data from the memory
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int DEPTH_BYTES = 128,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic              p0_req_write,
  input  logic [2:0]        p0_req_funct3,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [31:0]       p0_req_wdata,
  output logic              p0_rsp_valid,
  output logic [31:0]       p0_rsp_rdata,
  output logic              p0_rsp_err,

  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic              p1_req_write,
  input  logic [2:0]        p1_req_funct3,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [31:0]       p1_req_wdata,
  output logic              p1_rsp_valid,
  output logic [31:0]       p1_rsp_rdata,
  output logic              p1_rsp_err,

  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  // Returns 1 when the request must be rejected without touching memory.
  // The end address is formed one bit wider than the address so that an
  // address near the top of the address space cannot wrap into range.
  function automatic logic req_illegal(
    input logic              write,
    input logic [2:0]        funct3,
    input logic [ADDR_W-1:0] addr
  );
    logic [ADDR_W:0] size;
    logic [ADDR_W:0] end_addr;
    logic            bad;
    size = (ADDR_W+1)'(3'd1);
    bad  = 1'b0;
    case (funct3)
      3'b000: begin size = (ADDR_W+1)'(3'd1); bad = 1'b0;                end
      3'b001: begin size = (ADDR_W+1)'(3'd2); bad = addr[0];             end
      3'b010: begin size = (ADDR_W+1)'(3'd4); bad = addr[1] | addr[0];   end
      3'b100: begin size = (ADDR_W+1)'(3'd1); bad = write;               end
      3'b101: begin size = (ADDR_W+1)'(3'd2); bad = write | addr[0];     end
      default: begin size = (ADDR_W+1)'(3'd1); bad = 1'b1;              end
    endcase
    end_addr = {1'b0, addr} + size;
    bad      = bad | (end_addr > (ADDR_W+1)'(DEPTH_BYTES));
    return bad;
  endfunction

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic                write_q, write_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                err_q, err_d;
  logic                rsp0_valid_q, rsp0_valid_d;
  logic                rsp1_valid_q, rsp1_valid_d;
  logic                rsp0_err_q, rsp0_err_d;
  logic                rsp1_err_q, rsp1_err_d;
  logic [31:0]         rsp0_rdata_q, rsp0_rdata_d;
  logic [31:0]         rsp1_rdata_q, rsp1_rdata_d;

  logic                grant_valid_s;
  logic                grant_port_s;
  logic                sel_write_s;
  logic [2:0]          sel_funct3_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [31:0]         sel_wdata_s;
  logic [31:0]         rsp_rdata_s;

  // Round-robin grant: a lone requester wins, a tie goes to the port that was
  // not granted last. Gated by rst_n so nothing is accepted while in reset.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_port_s  = 1'b0;
    if ((state_q == ST_IDLE) && rst_n) begin
      if (p0_req_valid && p1_req_valid) begin
        grant_valid_s = 1'b1;
        grant_port_s  = ~last_grant_q;
      end else if (p0_req_valid) begin
        grant_valid_s = 1'b1;
        grant_port_s  = 1'b0;
      end else if (p1_req_valid) begin
        grant_valid_s = 1'b1;
        grant_port_s  = 1'b1;
      end else begin
        grant_valid_s = 1'b0;
        grant_port_s  = 1'b0;
      end
    end else begin
      grant_valid_s = 1'b0;
      grant_port_s  = 1'b0;
    end
  end

  assign p0_req_ready = grant_valid_s & ~grant_port_s;
  assign p1_req_ready = grant_valid_s &  grant_port_s;

  // Payload of the granted port.
  always_comb begin
    sel_write_s  = p0_req_write;
    sel_funct3_s = p0_req_funct3;
    sel_addr_s   = p0_req_addr;
    sel_wdata_s  = p0_req_wdata;
    if (grant_port_s) begin
      sel_write_s  = p1_req_write;
      sel_funct3_s = p1_req_funct3;
      sel_addr_s   = p1_req_addr;
      sel_wdata_s  = p1_req_wdata;
    end else begin
      sel_write_s  = p0_req_write;
      sel_funct3_s = p0_req_funct3;
      sel_addr_s   = p0_req_addr;
      sel_wdata_s  = p0_req_wdata;
    end
  end

  // Rejected requests and stores return zero read data.
  assign rsp_rdata_s = (!write_q && !err_q) ? mem_rdata : 32'd0;

  // Next-state logic: latch the granted request in IDLE, respond from ACCESS.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    write_d      = write_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    err_d        = err_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    rsp0_err_d   = 1'b0;
    rsp1_err_d   = 1'b0;
    rsp0_rdata_d = 32'd0;
    rsp1_rdata_d = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid_s) begin
          owner_d      = grant_port_s;
          last_grant_d = grant_port_s;
          write_d      = sel_write_s;
          funct3_d     = sel_funct3_s;
          addr_d       = sel_addr_s;
          wdata_d      = sel_wdata_s;
          err_d        = req_illegal(sel_write_s, sel_funct3_s, sel_addr_s);
          state_d      = ST_ACCESS;
        end else begin
          state_d      = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (owner_q) begin
          rsp1_valid_d = 1'b1;
          rsp1_err_d   = err_q;
          rsp1_rdata_d = rsp_rdata_s;
        end else begin
          rsp0_valid_d = 1'b1;
          rsp0_err_d   = err_q;
          rsp0_rdata_d = rsp_rdata_s;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Memory command is decoded from state so that reset removes it at once.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_funct3 = 3'd0;
    mem_addr   = {ADDR_W{1'b0}};
    mem_wdata  = 32'd0;
    if (state_q == ST_ACCESS) begin
      mem_read   = ~write_q & ~err_q;
      mem_write  =  write_q & ~err_q;
      mem_funct3 = funct3_q;
      mem_addr   = addr_q;
      mem_wdata  = wdata_q;
    end else begin
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_funct3 = 3'd0;
      mem_addr   = {ADDR_W{1'b0}};
      mem_wdata  = 32'd0;
    end
  end

  // State, latched request and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      write_q      <= 1'b0;
      funct3_q     <= 3'd0;
      addr_q       <= {ADDR_W{1'b0}};
      wdata_q      <= 32'd0;
      err_q        <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_err_q   <= 1'b0;
      rsp1_err_q   <= 1'b0;
      rsp0_rdata_q <= 32'd0;
      rsp1_rdata_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      write_q      <= write_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_err_q   <= rsp0_err_d;
      rsp1_err_q   <= rsp1_err_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

  assign p0_rsp_valid = rsp0_valid_q;
  assign p0_rsp_err   = rsp0_err_q;
  assign p0_rsp_rdata = rsp0_rdata_q;
  assign p1_rsp_valid = rsp1_valid_q;
  assign p1_rsp_err   = rsp1_err_q;
  assign p1_rsp_rdata = rsp1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter with a 128-byte memory model attached to
// the mem_* lines. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        p0_req_valid, p0_req_ready, p0_req_write;
  logic [2:0]  p0_req_funct3;
  logic [31:0] p0_req_addr, p0_req_wdata;
  logic        p0_rsp_valid, p0_rsp_err;
  logic [31:0] p0_rsp_rdata;
  logic        p1_req_valid, p1_req_ready, p1_req_write;
  logic [2:0]  p1_req_funct3;
  logic [31:0] p1_req_addr, p1_req_wdata;
  logic        p1_rsp_valid, p1_rsp_err;
  logic [31:0] p1_rsp_rdata;
  logic        mem_read, mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_arbiter #(.DEPTH_BYTES(128), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
    .p0_req_write(p0_req_write), .p0_req_funct3(p0_req_funct3),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
    .p1_req_write(p1_req_write), .p1_req_funct3(p1_req_funct3),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [7:0] mem_model [0:127];
  logic [6:0] ma;
  logic       mem_clear;

  always_comb begin
    ma = mem_addr[6:0];
    case (mem_funct3)
      3'b000: mem_rdata = {{24{mem_model[ma][7]}}, mem_model[ma]};
      3'b001: mem_rdata = {{16{mem_model[ma+7'd1][7]}}, mem_model[ma+7'd1], mem_model[ma]};
      3'b010: mem_rdata = {mem_model[ma+7'd3], mem_model[ma+7'd2], mem_model[ma+7'd1], mem_model[ma]};
      3'b100: mem_rdata = {24'd0, mem_model[ma]};
      3'b101: mem_rdata = {16'd0, mem_model[ma+7'd1], mem_model[ma]};
      default: mem_rdata = 32'd0;
    endcase
  end

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 128; i++) mem_model[i] <= 8'd0;
    end else if (mem_write) begin
      case (mem_funct3)
        3'b000: mem_model[ma] <= mem_wdata[7:0];
        3'b001: begin
          mem_model[ma]      <= mem_wdata[7:0];
          mem_model[ma+7'd1] <= mem_wdata[15:8];
        end
        3'b010: begin
          mem_model[ma]      <= mem_wdata[7:0];
          mem_model[ma+7'd1] <= mem_wdata[15:8];
          mem_model[ma+7'd2] <= mem_wdata[23:16];
          mem_model[ma+7'd3] <= mem_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

  // ---------------- helpers ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int port, input logic v, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
    if (port == 0) begin
      p0_req_valid = v; p0_req_write = wr; p0_req_funct3 = f3;
      p0_req_addr = addr; p0_req_wdata = wd;
    end else begin
      p1_req_valid = v; p1_req_write = wr; p1_req_funct3 = f3;
      p1_req_addr = addr; p1_req_wdata = wd;
    end
  endtask

  // One isolated transaction on one port, checking every phase.
  task automatic do_req(input string tag, input int port, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
    logic rdy, own_v, oth_v, own_e;
    logic [31:0] own_d;
    int waited;
    @(negedge clk);
    set_req(port, 1'b1, wr, f3, addr, wd);
    #1;
    waited = 0;
    rdy = (port == 0) ? p0_req_ready : p1_req_ready;
    while (!rdy && waited < 10) begin
      @(negedge clk); #1;
      waited++;
      rdy = (port == 0) ? p0_req_ready : p1_req_ready;
    end
    check_eq({tag, "_ready"}, {31'd0, rdy}, 32'd1);
    @(posedge clk); #1;
    set_req(port, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    @(negedge clk);
    check_eq({tag, "_mem_write"}, {31'd0, mem_write}, {31'd0, wr & ~exp_err});
    check_eq({tag, "_mem_read"}, {31'd0, mem_read}, {31'd0, ~wr & ~exp_err});
    @(negedge clk);
    own_v = (port == 0) ? p0_rsp_valid : p1_rsp_valid;
    oth_v = (port == 0) ? p1_rsp_valid : p0_rsp_valid;
    own_e = (port == 0) ? p0_rsp_err   : p1_rsp_err;
    own_d = (port == 0) ? p0_rsp_rdata : p1_rsp_rdata;
    check_eq({tag, "_rsp_valid"}, {31'd0, own_v}, 32'd1);
    check_eq({tag, "_other_valid"}, {31'd0, oth_v}, 32'd0);
    check_eq({tag, "_rsp_err"}, {31'd0, own_e}, {31'd0, exp_err});
    check_eq({tag, "_rdata"}, own_d, exp_rd);
    @(negedge clk);
    own_v = (port == 0) ? p0_rsp_valid : p1_rsp_valid;
    check_eq({tag, "_rsp_pulse"}, {31'd0, own_v}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"}, {30'd0, p1_req_ready, p0_req_ready}, 32'd0);
    check_eq({tag, "_mem_en"}, {30'd0, mem_read, mem_write}, 32'd0);
    check_eq({tag, "_mem_addr"}, mem_addr, 32'd0);
    check_eq({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check_eq({tag, "_mem_f3"}, {29'd0, mem_funct3}, 32'd0);
    check_eq({tag, "_rsp"}, {28'd0, p1_rsp_valid, p1_rsp_err, p0_rsp_valid, p0_rsp_err}, 32'd0);
    check_eq({tag, "_rdata"}, p0_rsp_rdata | p1_rsp_rdata, 32'd0);
  endtask

  // ---------------- contention tables ----------------
  logic [2:0]  c_f3   [0:1][0:3];
  logic [31:0] c_addr [0:1][0:3];
  logic [31:0] c_exp  [0:1][0:3];

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout: got 0x%08h expected 0x%08h", 32'd1, 32'd0);
    $fatal(1, "time limit");
  end

  // ---------------- stimulus ----------------
  initial begin
    int gport[$];
    int gcyc[$];
    int rport[$];
    int rcyc[$];
    logic [31:0] rdat[$];
    logic rerr[$];
    int g0, g1;

    c_f3[0][0] = 3'b010; c_addr[0][0] = 32'h10; c_exp[0][0] = 32'hDEADBEEF;
    c_f3[0][1] = 3'b100; c_addr[0][1] = 32'h21; c_exp[0][1] = 32'h00000080;
    c_f3[0][2] = 3'b010; c_addr[0][2] = 32'h00; c_exp[0][2] = 32'hCAFEF00D;
    c_f3[0][3] = 3'b010; c_addr[0][3] = 32'h7C; c_exp[0][3] = 32'h0BADF00D;
    c_f3[1][0] = 3'b000; c_addr[1][0] = 32'h21; c_exp[1][0] = 32'hFFFFFF80;
    c_f3[1][1] = 3'b010; c_addr[1][1] = 32'h00; c_exp[1][1] = 32'hCAFEF00D;
    c_f3[1][2] = 3'b101; c_addr[1][2] = 32'h20; c_exp[1][2] = 32'h00008000;
    c_f3[1][3] = 3'b010; c_addr[1][3] = 32'h10; c_exp[1][3] = 32'hDEADBEEF;

    rst_n = 1'b0;
    mem_clear = 1'b1;
    set_req(0, 1'b1, 1'b1, 3'b010, 32'h10, 32'h1);
    set_req(1, 1'b1, 1'b0, 3'b010, 32'h20, 32'h2);
    @(negedge clk);
    @(negedge clk);
    mem_clear = 1'b0;
    check_all_zero("reset");
    set_req(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic store/load on port 0
    do_req("sw10",  0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    do_req("lw10",  0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    // Sign versus zero extension
    do_req("sb21",  1, 1'b1, 3'b000, 32'h21, 32'h00000080, 32'h0, 1'b0);
    do_req("lb21",  0, 1'b0, 3'b000, 32'h21, 32'h0, 32'hFFFFFF80, 1'b0);
    do_req("lbu21", 0, 1'b0, 3'b100, 32'h21, 32'h0, 32'h00000080, 1'b0);
    do_req("lh20",  1, 1'b0, 3'b001, 32'h20, 32'h0, 32'hFFFF8000, 1'b0);
    // Errors
    do_req("sw00",  1, 1'b1, 3'b010, 32'h00, 32'hCAFEF00D, 32'h0, 1'b0);
    do_req("e_sw02", 0, 1'b1, 3'b010, 32'h02, 32'h55555555, 32'h0, 1'b1);
    do_req("e_lh7f", 1, 1'b0, 3'b001, 32'h7F, 32'h0, 32'h0, 1'b1);
    do_req("e_lw80", 0, 1'b0, 3'b010, 32'h80, 32'h0, 32'h0, 1'b1);
    do_req("e_st100", 1, 1'b1, 3'b100, 32'h00, 32'h11111111, 32'h0, 1'b1);
    do_req("e_ld011", 0, 1'b0, 3'b011, 32'h00, 32'h0, 32'h0, 1'b1);
    do_req("e_wrap", 0, 1'b0, 3'b000, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1);
    do_req("lw00_kept", 0, 1'b0, 3'b010, 32'h00, 32'h0, 32'hCAFEF00D, 1'b0);
    do_req("sw7c",  1, 1'b1, 3'b010, 32'h7C, 32'h0BADF00D, 32'h0, 1'b0);
    do_req("lw7c",  0, 1'b0, 3'b010, 32'h7C, 32'h0, 32'h0BADF00D, 1'b0);

    // Contention after reset: last_grant back to 1, so port 0 wins first
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    g0 = 0; g1 = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (g0 < 4) set_req(0, 1'b1, 1'b0, c_f3[0][g0], c_addr[0][g0], 32'd0);
      else        set_req(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      if (g1 < 4) set_req(1, 1'b1, 1'b0, c_f3[1][g1], c_addr[1][g1], 32'd0);
      else        set_req(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      #1;
      check_eq("ctn_ready_excl", {31'd0, p0_req_ready & p1_req_ready}, 32'd0);
      check_eq("ctn_rsp_excl", {31'd0, p0_rsp_valid & p1_rsp_valid}, 32'd0);
      if (p0_req_ready) begin gport.push_back(0); gcyc.push_back(cyc); g0++; end
      if (p1_req_ready) begin gport.push_back(1); gcyc.push_back(cyc); g1++; end
      if (p0_rsp_valid) begin
        rport.push_back(0); rcyc.push_back(cyc); rdat.push_back(p0_rsp_rdata); rerr.push_back(p0_rsp_err);
      end
      if (p1_rsp_valid) begin
        rport.push_back(1); rcyc.push_back(cyc); rdat.push_back(p1_rsp_rdata); rerr.push_back(p1_rsp_err);
      end
    end
    check_eq("ctn_ngrant", gport.size(), 32'd8);
    check_eq("ctn_nrsp", rport.size(), 32'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < gport.size()) begin
        check_eq($sformatf("ctn_gport%0d", k), gport[k], k % 2);
        check_eq($sformatf("ctn_gcyc%0d", k), gcyc[k], 2 * k);
      end
      if (k < rport.size()) begin
        check_eq($sformatf("ctn_rport%0d", k), rport[k], k % 2);
        check_eq($sformatf("ctn_rcyc%0d", k), rcyc[k], 2 * k + 2);
        check_eq($sformatf("ctn_rdata%0d", k), rdat[k], c_exp[k % 2][k / 2]);
        check_eq($sformatf("ctn_rerr%0d", k), {31'd0, rerr[k]}, 32'd0);
      end
    end

    // Reset during the access cycle of SW 0x00
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 3'b010, 32'h00, 32'h12345678);
    #1;
    check_eq("rma_ready", {31'd0, p0_req_ready}, 32'd1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    set_req(1, 1'b1, 1'b1, 3'b010, 32'h04, 32'h9);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("rma_held");
    @(negedge clk);
    check_all_zero("rma_held2");
    set_req(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("rma_no_rsp", {30'd0, p1_rsp_valid, p0_rsp_valid}, 32'd0);
    end
    do_req("rma_lw00", 0, 1'b0, 3'b010, 32'h00, 32'h0, 32'hCAFEF00D, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
